a_channel: RTL
==============

# a_channel

Subordinate-side OBI request (A) channel. It accepts requests from the master via the req/gnt handshake and buffers them in a small FIFO. It forwards each request to the cache controller over a valid/ready interface, and limits the number of accepted-but-unanswered transactions. It pairs with the response-channel block: that block's completed `rvalid` beats feed back into this one as `rsp_done_in`.

## Interface
- `ADDR_WIDTH`, default 32: request address width.
- `DATA_WIDTH`, default 64: write data width; must be a multiple of 8.
- `ID_WIDTH`, default 4: transaction ID width.
- `FIFO_DEPTH`, default 2: request buffer entries; power of two, ≥2.
- `MAX_OUTSTANDING`, default 4: maximum accepted requests without a completed response; ≥1.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `obi_req`  in  `if_types_pkg::obi_req_t`: master request; uses `req`, `a.addr`, `a.we`, `a.be`, `a.wdata`, `a.aid`.
- `gnt_out`  out  1: grant; merged into `obi_rsp_t.gnt` at top level.
- `req_valid_out`  out  1: FIFO head valid toward controller.
- `req_ready_in`  in  1: controller consumes head.
- `addr_out`  out  `ADDR_WIDTH`: head address.
- `we_out`  out  1: head write enable.
- `be_out`  out  `DATA_WIDTH/8`: head byte enables.
- `wdata_out`  out  `DATA_WIDTH`: head write data.
- `aid_out`  out  `ID_WIDTH`: head ID.
- `err_out`  out  1: head flagged as unsupported (see Configuration).
- `rsp_done_in`  in  1: one-cycle pulse per response delivered to master.
- `outstanding_out`  out  `$clog2(MAX_OUTSTANDING+1)`: current outstanding count.

## Operation
- Accept condition: `obi_req.req && gnt_out` at a rising edge. On accept:
  - Push {addr, we, be, wdata, aid, err} into the FIFO.
  - Increment the outstanding counter.
- Grant rule: `gnt_out = !fifo_full && (outstanding < MAX_OUTSTANDING)`.
  - Combinational from registered state only; no path from `obi_req.req`.
- Pop condition: `req_valid_out && req_ready_in`. The head advances at the edge.
- Simultaneous push and pop:
  - Legal whenever the FIFO is non-empty and grant is high.
  - Occupancy is unchanged; ordering is preserved.
- Counter updates:
  - Accept and `rsp_done_in` in the same cycle: counter unchanged.
  - `rsp_done_in` at count 0: ignored; counter stays 0, no underflow.
- The counter never exceeds `MAX_OUTSTANDING`, because grant blocks the increment.
- Read/write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Full and empty are distinguished by an occupancy count of width `$clog2(FIFO_DEPTH+1)`.
- Output fields show the head entry whenever `req_valid_out=1`. With the FIFO empty they hold their last value and must not be consumed.
- No state machine beyond the FIFO and the counter. The block is purely order-preserving and never reorders or drops requests.

## Timing
- Reset values (asynchronous, immediate):
  - `req_valid_out=0`, `outstanding_out=0`, `gnt_out=1`, `err_out=0`.
  - All data outputs are 0; FIFO is empty; pointers are 0.
- Latency:
  - A request accepted at edge N appears on `req_valid_out` from edge N onward, i.e. it is visible in cycle N+1.
  - No combinational bypass from `obi_req` to the controller outputs.
- Throughput: one accept per cycle sustained, provided the controller pops every cycle and the outstanding limit is not hit.
- Grant deasserts in the cycle after the accept that fills the FIFO or reaches the limit. It reasserts in the cycle after the pop or `rsp_done_in` that frees space.
- Reset asserted mid-transaction:
  - FIFO contents and the counter are discarded.
  - In-flight controller work is not tracked. The top level resets the controller concurrently.

## Configuration
- Macro: `A_CHANNEL_BE_CHECK_EN`.
- When defined: a write (`we=1`) with `be` not all-ones is stored with `err=1`. Reads and full-width writes are stored with `err=0`. The request is still accepted and forwarded; the controller returns an error response.
- When undefined: `err_out` is tied to 0 and no check logic is synthesised.

## Test plan
- Reset, then a single read of addr 0x40 with aid 3 → `gnt_out=1`. `req_valid_out` is high the next cycle with `addr_out=0x40`, `we_out=0`, `aid_out=3`. `outstanding_out=1` until `rsp_done_in` is pulsed, then 0.
- Controller stalled (`req_ready_in=0`), master requests every cycle with `FIFO_DEPTH=2` → exactly 2 accepts, then `gnt_out=0`. After one pop, grant returns the next cycle; the third request is accepted and FIFO order is preserved.
- `MAX_OUTSTANDING=4`, controller always ready, no `rsp_done_in` → 4 accepts, then `gnt_out=0`. One `rsp_done_in` pulse → `outstanding_out=3`, grant reasserts and a fifth accept follows.
- Accept and `rsp_done_in` in the same cycle at count 2 → count stays 2. `rsp_done_in` at count 0 → stays 0.
- With `A_CHANNEL_BE_CHECK_EN` defined:
  - Write with `be=0xFF` → `err_out=0`.
  - Write with `be=0x0F` → `err_out=1`.
  - Read with `be=0x00` → `err_out=0`.
  - Without the macro, all three give `err_out=0`.
- `rst_n` dropped while the FIFO holds 2 entries and count=3 → immediately `req_valid_out=0`, `outstanding_out=0`, `gnt_out=1`. The first post-reset request is the first entry output.

Source files
------------

// File: rtl/if_types_pkg.sv
// Shared OBI request types seen at the subordinate boundary.
// Field widths match the a_channel default parameters.
// req: request strobe; a: address-phase payload (addr, we, be, wdata, aid).
package if_types_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [3:0]  aid;
    } obi_a_t;

    typedef struct packed {
        logic   req;
        obi_a_t a;
    } obi_req_t;

endpackage

// File: rtl/a_channel.sv
// Purpose: subordinate OBI A-channel; buffers granted requests in a FIFO toward the cache controller.
// Latency: request accepted at edge N is at the FIFO head (req_valid_out) from edge N; no comb bypass.
// Backpressure: gnt_out drops when FIFO is full or MAX_OUTSTANDING requests await rsp_done_in.
//
// Ports: clk/rst_n (async active-low); obi_req in; gnt_out grant; req_valid_out/req_ready_in
// head handshake with addr_out/we_out/be_out/wdata_out/aid_out/err_out payload; rsp_done_in
// completion pulse from the response channel; outstanding_out current in-flight count.
// Optional macro A_CHANNEL_BE_CHECK_EN: flags partial-byte-enable writes with err_out=1.
module a_channel #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int ID_WIDTH        = 4,
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  if_types_pkg::obi_req_t               obi_req,
    output logic                                 gnt_out,
    output logic                                 req_valid_out,
    input  logic                                 req_ready_in,
    output logic [ADDR_WIDTH-1:0]                addr_out,
    output logic                                 we_out,
    output logic [DATA_WIDTH/8-1:0]              be_out,
    output logic [DATA_WIDTH-1:0]                wdata_out,
    output logic [ID_WIDTH-1:0]                  aid_out,
    output logic                                 err_out,
    input  logic                                 rsp_done_in,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_out
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [BE_W-1:0]       be;
        logic [DATA_WIDTH-1:0] wdata;
        logic [ID_WIDTH-1:0]   aid;
    } entry_t;

    entry_t             mem [FIFO_DEPTH];
    entry_t             push_dat;
    entry_t             head_dat;
    entry_t             last_q;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [OUT_W-1:0]   outstanding;
    logic               head_vld;
    logic               push;
    logic               pop;
    logic               rsp_dec;

    // Grant depends only on registered state, so there is no req->gnt loop.
    assign gnt_out  = (count != CNT_W'(FIFO_DEPTH)) && (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign head_vld = (count != '0);
    assign push     = obi_req.req && gnt_out;
    assign pop      = head_vld && req_ready_in;
    // A completion with nothing in flight cannot belong to us; drop it to avoid underflow.
    assign rsp_dec  = rsp_done_in && (outstanding != '0);

    always_comb begin
        push_dat       = '0;
        push_dat.addr  = obi_req.a.addr[ADDR_WIDTH-1:0];
        push_dat.we    = obi_req.a.we;
        push_dat.be    = obi_req.a.be[BE_W-1:0];
        push_dat.wdata = obi_req.a.wdata[DATA_WIDTH-1:0];
        push_dat.aid   = obi_req.a.aid[ID_WIDTH-1:0];
    end

    // When empty, the head fields keep showing the last entry that was at the head.
    assign head_dat = head_vld ? mem[rd_ptr] : last_q;

    // Storage needs no reset: it is only observed through head_vld.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            last_q      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (head_vld) begin
                last_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            case ({push, rsp_dec})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef A_CHANNEL_BE_CHECK_EN
    logic err_mem [FIFO_DEPTH];
    logic err_last;
    logic push_err;

    // Partial writes are forwarded but marked so the controller answers with an error.
    assign push_err = obi_req.a.we && (obi_req.a.be[BE_W-1:0] != '1);

    always_ff @(posedge clk) begin
        if (push) begin
            err_mem[wr_ptr] <= push_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_last <= 1'b0;
        end else if (head_vld) begin
            err_last <= err_mem[rd_ptr];
        end
    end

    assign err_out = head_vld ? err_mem[rd_ptr] : err_last;
`else
    assign err_out = 1'b0;
`endif

    assign req_valid_out   = head_vld;
    assign addr_out        = head_dat.addr;
    assign we_out          = head_dat.we;
    assign be_out          = head_dat.be;
    assign wdata_out       = head_dat.wdata;
    assign aid_out         = head_dat.aid;
    assign outstanding_out = outstanding;

endmodule
